nand_ctrl_counter_bank: RTL and testbench

//   Counter bank for the NAND controller sequencer, with two independent registered counters.

---
 rtl/nand_ctrl_counter_bank.sv | 44 ++++
 tb/tb_nand_ctrl_counter_bank.sv | 132 +++++++++++++
 2 files changed

// File: rtl/nand_ctrl_counter_bank.sv
// nand_ctrl_counter_bank: modulo up/down counter with clamped load, plus clearable free-running delay counter
module nand_ctrl_counter_bank #(
    parameter int U_WIDTH   = 8,
    parameter int U_MODULUS = 256,
    parameter int D_WIDTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               u_up,
    input  logic               u_down,
    input  logic               u_set,
    input  logic [U_WIDTH-1:0] u_in,
    output logic [U_WIDTH-1:0] u_out,
    input  logic               d_en,
    input  logic               d_clr,
    output logic [D_WIDTH-1:0] d_out
);
    localparam logic [U_WIDTH:0]   U_MOD_X = (U_WIDTH+1)'(U_MODULUS);
    localparam logic [U_WIDTH-1:0] U_TOP   = U_WIDTH'(U_MODULUS - 1);
    generate
        if (U_MODULUS < 2 || U_MODULUS > 2**U_WIDTH) begin : g_bad_modulus
            $error("nand_ctrl_counter_bank: U_MODULUS must lie in 2..2**U_WIDTH");
        end
    endgenerate
    logic [U_WIDTH-1:0] u_load, u_step, u_next;
    logic [D_WIDTH-1:0] d_next;
    always_comb begin
        u_load = ({1'b0, u_in} < U_MOD_X) ? u_in : U_TOP;
        u_step = u_up ? ((u_out == U_TOP) ? '0 : u_out + 1'b1)
                      : ((u_out == '0) ? U_TOP : u_out - 1'b1);
        // up and down together cancel, so only a lone enable steps the count
        u_next = u_set ? u_load : (u_up ^ u_down) ? u_step : u_out;
        d_next = d_clr ? '0 : d_en ? d_out + 1'b1 : d_out;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            u_out <= '0;
            d_out <= '0;
        end else begin
            u_out <= u_next;
            d_out <= d_next;
        end
    end
endmodule

// File: tb/tb_nand_ctrl_counter_bank.sv
// tb_nand_ctrl_counter_bank: two builds (12b/4096 and 4b/mod 7) driven in lockstep against a modular-arithmetic model
module tb_nand_ctrl_counter_bank;
    logic        clk = 1'b0;
    logic        rst = 1'b0, u_up = 1'b0, u_down = 1'b0, u_set = 1'b0, d_en = 1'b0, d_clr = 1'b0;
    logic [11:0] u_in = '0;
    logic [3:0]  u_in7 = '0;
    logic [11:0] u_out;
    logic [7:0]  d_out;
    logic [3:0]  u_out7;
    logic [3:0]  d_out4;
    int checks = 0, errors = 0;
    int mu = 0, md = 0, mu7 = 0, md4 = 0;
    bit valid = 1'b0;

    always #5 clk = ~clk;

    nand_ctrl_counter_bank #(.U_WIDTH(12), .U_MODULUS(4096), .D_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .u_up(u_up), .u_down(u_down), .u_set(u_set), .u_in(u_in),
        .u_out(u_out), .d_en(d_en), .d_clr(d_clr), .d_out(d_out));

    nand_ctrl_counter_bank #(.U_WIDTH(4), .U_MODULUS(7), .D_WIDTH(4)) dut7 (
        .clk(clk), .rst(rst), .u_up(u_up), .u_down(u_down), .u_set(u_set), .u_in(u_in7),
        .u_out(u_out7), .d_en(d_en), .d_clr(d_clr), .d_out(d_out4));

    function automatic int u_model(input int cur, input int modulus, input int ld);
        if (u_set) return (ld < modulus) ? ld : modulus - 1;
        if (u_up && !u_down) return (cur + 1) % modulus;
        if (u_down && !u_up) return (cur + modulus - 1) % modulus;
        return cur;
    endfunction

    function automatic int d_model(input int cur, input int span);
        if (d_clr) return 0;
        if (d_en) return (cur + 1) % span;
        return cur;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            valid <= 1'b1;
            mu <= 0; md <= 0; mu7 <= 0; md4 <= 0;
        end else begin
            mu  <= u_model(mu, 4096, int'(u_in));
            mu7 <= u_model(mu7, 7, int'(u_in7));
            md  <= d_model(md, 256);
            md4 <= d_model(md4, 16);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            chk("model u12", 32'(u_out), 32'(mu));
            chk("model d8", 32'(d_out), 32'(md));
            chk("model u7", 32'(u_out7), 32'(mu7));
            chk("model d4", 32'(d_out4), 32'(md4));
        end
    end

    // inputs change at a negedge and are sampled by the following posedge
    task automatic cyc(input logic r, input logic up, input logic dn, input logic st,
                       input int i12, input int i7, input logic en, input logic clr);
        rst = r; u_up = up; u_down = dn; u_set = st;
        u_in = 12'(i12); u_in7 = 4'(i7); d_en = en; d_clr = clr;
        @(negedge clk);
    endtask

    initial begin
        bit seen255;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1234, 3, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 1, 5, 5, 1, 0);
        chk("reset u12", 32'(u_out), 0);
        chk("reset d8", 32'(d_out), 0);
        chk("reset u7", 32'(u_out7), 0);

        cyc(0, 0, 0, 1, 8, 8, 0, 0);
        chk("load 8", 32'(u_out), 8);
        chk("load 8 clamp m7", 32'(u_out7), 6);
        repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 0);
        chk("inc to 11", 32'(u_out), 11);
        cyc(0, 1, 0, 1, 0, 0, 0, 0);
        chk("load beats up", 32'(u_out), 0);

        cyc(0, 0, 0, 1, 4095, 9, 0, 0);
        chk("load 4095", 32'(u_out), 4095);
        chk("load 9 clamps to 6", 32'(u_out7), 6);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        chk("wrap up u12", 32'(u_out), 0);
        chk("wrap up u7", 32'(u_out7), 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        chk("wrap down u12", 32'(u_out), 4095);
        chk("wrap down u7", 32'(u_out7), 6);
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        chk("up+down hold", 32'(u_out), 4095);

        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (20) cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("delay 20", 32'(d_out), 20);
        chk("delay 20 d4", 32'(d_out4), 4);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("delay hold", 32'(d_out), 20);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        chk("clr beats en", 32'(d_out), 0);

        seen255 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
            if (d_out == 8'd255) seen255 = 1'b1;
        end
        chk("d wrap passed 255", 32'(seen255), 1);
        chk("d wrap to 0", 32'(d_out), 0);

        for (int i = 0; i < 10000; i++) begin
            cyc($urandom_range(0, 499) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 7) == 0, $urandom_range(0, 4095), $urandom_range(0, 15),
                $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
